// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
package serial_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder with a registered carry; clr wins over en.
module serial_fa_cell (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   logic c_q;

   assign s = a ^ b ^ c_q;
   assign c = c_q;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         c_q <= 1'b0;
      end else if (en) begin
         c_q <= (a & b) | (a & c_q) | (b & c_q);
      end
   end

endmodule

// File: rtl/serial_add_ctrl.sv
// Word-level valid/ready front end that streams two operands LSB-first
// through a serial adder cell and presents {carry_out, result}.
module serial_add_ctrl
   import serial_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             busy,
   output logic             sum_bit
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr, b_sr, sum_q;
   logic [CNT_W-1:0] cnt_q;
   logic             fa_clr, fa_en;
   logic             last_bit;

   assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      fa_clr    = 1'b0;
      fa_en     = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               fa_clr  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            busy  = 1'b1;
            fa_en = 1'b1;
            if (last_bit) begin
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr  <= '0;
         b_sr  <= '0;
         sum_q <= '0;
         cnt_q <= '0;
      end else if (state_q == IDLE && in_valid) begin
         a_sr  <= a_in;
         b_sr  <= b_in;
         sum_q <= '0;
         cnt_q <= '0;
      end else if (state_q == SHIFT) begin
         a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
         b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
         sum_q <= {sum_bit, sum_q[WIDTH-1:1]};
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   serial_fa_cell u_fa (
      .clk (clk),
      .rst (rst),
      .clr (fa_clr),
      .en  (fa_en),
      .a   (a_sr[0]),
      .b   (b_sr[0]),
      .s   (sum_bit),
      .c   (carry_out)
   );

   assign result = sum_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomised and directed checks of serial_add_ctrl at WIDTH=4 and WIDTH=8.
module tb_serial_add_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sel = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b1;
   logic [7:0] a_drv = '0;
   logic [7:0] b_drv = '0;

   logic       ir4, ov4, c4, busy4, sb4;
   logic [3:0] r4;
   logic       ir8, ov8, c8, busy8, sb8;
   logic [7:0] r8;

   logic       in_ready_m, out_valid_m, carry_m, busy_m, sum_bit_m;
   logic [7:0] result_m;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(ir4),
      .a_in(a_drv[3:0]), .b_in(b_drv[3:0]), .out_valid(ov4), .out_ready(out_ready),
      .result(r4), .carry_out(c4), .busy(busy4), .sum_bit(sb4)
   );

   serial_add_ctrl #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(ir8),
      .a_in(a_drv), .b_in(b_drv), .out_valid(ov8), .out_ready(out_ready),
      .result(r8), .carry_out(c8), .busy(busy8), .sum_bit(sb8)
   );

   assign in_ready_m  = sel ? ir8   : ir4;
   assign out_valid_m = sel ? ov8   : ov4;
   assign carry_m     = sel ? c8    : c4;
   assign busy_m      = sel ? busy8 : busy4;
   assign sum_bit_m   = sel ? sb8   : sb4;
   assign result_m    = sel ? r8    : {4'h0, r4};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Ends with the DUT sitting in DONE (result presented, not yet consumed).
   task automatic do_op(input bit s, input logic [7:0] a, input logic [7:0] b,
                        input string nm, output int waited);
      int unsigned w;
      logic [7:0]  mask;
      logic [8:0]  sum;
      logic [7:0]  exp_res;
      logic        exp_c;
      logic [7:0]  bits;
      int          n;
      w       = s ? 8 : 4;
      mask    = s ? 8'hFF : 8'h0F;
      sum     = {1'b0, a & mask} + {1'b0, b & mask};
      exp_res = sum[7:0] & mask;
      exp_c   = s ? sum[8] : sum[4];
      sel = s; a_drv = a; b_drv = b; in_valid = 1'b1;
      waited = 0;
      while (!in_ready_m && waited < 50) begin
         step();
         waited++;
      end
      n_checks++;
      if (in_ready_m !== 1'b1) begin
         n_fail++;
         $display("FAIL %s accept_timeout: in_ready=%b required 1", nm, in_ready_m);
      end
      step();
      in_valid = 1'b0;
      n = 0;
      bits = '0;
      while (!out_valid_m && n < 64) begin
         if (busy_m && n < 8) bits[n] = sum_bit_m;
         step();
         n++;
      end
      n_checks++;
      if (n != int'(w)) begin
         n_fail++;
         $display("FAIL %s latency: got %0d cycles required %0d", nm, n, w);
      end
      n_checks++;
      if (result_m !== exp_res) begin
         n_fail++;
         $display("FAIL %s result: got %h required %h", nm, result_m, exp_res);
      end
      n_checks++;
      if (carry_m !== exp_c) begin
         n_fail++;
         $display("FAIL %s carry_out: got %b required %b", nm, carry_m, exp_c);
      end
      n_checks++;
      if ((bits & mask) !== exp_res) begin
         n_fail++;
         $display("FAIL %s sum_bit_seq: got %b required %b", nm, bits & mask, exp_res);
      end
   endtask

   task automatic finish_op(input string nm);
      out_ready = 1'b1;
      step();
      n_checks++;
      if (out_valid_m !== 1'b0 || in_ready_m !== 1'b1) begin
         n_fail++;
         $display("FAIL %s release: out_valid=%b in_ready=%b required 0/1", nm, out_valid_m, in_ready_m);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         sel = (i == 1);
         #0;
         n_checks++;
         if (in_ready_m !== 1'b1 || out_valid_m !== 1'b0 || busy_m !== 1'b0 ||
             result_m !== 8'h00 || carry_m !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state w%0d: ir=%b ov=%b busy=%b res=%h c=%b required 1/0/0/00/0",
                     sel ? 8 : 4, in_ready_m, out_valid_m, busy_m, result_m, carry_m);
         end
      end
      sel = 1'b0;
   endtask

   task automatic test_basic();
      int w;
      out_ready = 1'b1;
      do_op(1'b0, 8'd11, 8'd5, "add_11_5", w);
      finish_op("add_11_5");
   endtask

   task automatic test_back_to_back();
      int w;
      out_ready = 1'b1;
      do_op(1'b0, 8'd7, 8'd8, "add_7_8", w);
      // Next operands held valid while DONE exits; acceptance must wait one cycle.
      do_op(1'b0, 8'd15, 8'd15, "add_15_15", w);
      n_checks++;
      if (w != 1) begin
         n_fail++;
         $display("FAIL b2b_wait: got %0d cycles required 1", w);
      end
      finish_op("add_15_15");
   endtask

   task automatic test_backpressure();
      int w;
      out_ready = 1'b0;
      do_op(1'b0, 8'd9, 8'd12, "bp_9_12", w);
      for (int i = 0; i < 5; i++) begin
         in_valid = $urandom_range(0, 1);
         a_drv    = 8'($urandom);
         step();
         n_checks++;
         if (out_valid_m !== 1'b1 || result_m !== 8'h05 || carry_m !== 1'b1 || in_ready_m !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: ov=%b res=%h c=%b ir=%b required 1/05/1/0",
                     i, out_valid_m, result_m, carry_m, in_ready_m);
         end
      end
      in_valid = 1'b0;
      finish_op("bp_release");
      step();
      n_checks++;
      if (out_valid_m !== 1'b0 || busy_m !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_single_transfer: ov=%b busy=%b required 0/0", out_valid_m, busy_m);
      end
   endtask

   task automatic test_reset_mid();
      int w;
      out_ready = 1'b1;
      sel = 1'b0; a_drv = 8'd5; b_drv = 8'd6; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_checks++;
      if (in_ready_m !== 1'b1 || out_valid_m !== 1'b0 || busy_m !== 1'b0 ||
          result_m !== 8'h00 || carry_m !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: ir=%b ov=%b busy=%b res=%h c=%b required 1/0/0/00/0",
                  in_ready_m, out_valid_m, busy_m, result_m, carry_m);
      end
      for (int i = 0; i < 6; i++) begin
         step();
         n_checks++;
         if (out_valid_m !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_no_pulse[%0d]: out_valid=%b required 0", i, out_valid_m);
         end
      end
      do_op(1'b0, 8'd3, 8'd1, "add_3_1", w);
      finish_op("add_3_1");
   endtask

   task automatic test_width8();
      int w;
      out_ready = 1'b1;
      do_op(1'b1, 8'd200, 8'd100, "w8_200_100", w);
      finish_op("w8_200_100");
      do_op(1'b1, 8'd0, 8'd0, "w8_0_0", w);
      finish_op("w8_0_0");
      do_op(1'b1, 8'd255, 8'd1, "w8_255_1", w);
      finish_op("w8_255_1");
   endtask

   task automatic test_random(input bit s, input int nops);
      int unsigned exp_q[$];
      int unsigned exp_v, got_v;
      int unsigned w;
      logic [7:0]  mask;
      int          accepted, received, cycles;
      w = s ? 8 : 4;
      mask = s ? 8'hFF : 8'h0F;
      sel = s;
      accepted = 0; received = 0; cycles = 0;
      while (received < nops && cycles < 30000) begin
         in_valid  = (accepted < nops) && ($urandom_range(0, 3) != 0);
         a_drv     = 8'($urandom) & mask;
         b_drv     = 8'($urandom) & mask;
         out_ready = ($urandom_range(0, 3) != 0);
         if (in_valid && in_ready_m) begin
            exp_q.push_back(int'(a_drv) + int'(b_drv));
            accepted++;
            n_checks++;
            if (exp_q.size() != 1) begin
               n_fail++;
               $display("FAIL rnd_w%0d overlap: in flight %0d required 1", w, exp_q.size());
            end
         end
         if (out_valid_m && out_ready) begin
            got_v = (int'(carry_m) << w) | int'(result_m & mask);
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL rnd_w%0d spurious: got %0d required none", w, got_v);
            end else begin
               exp_v = exp_q.pop_front();
               if (got_v !== exp_v) begin
                  n_fail++;
                  $display("FAIL rnd_w%0d sum[%0d]: got %0d required %0d", w, received, got_v, exp_v);
               end
            end
            received++;
         end
         step();
         cycles++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      n_checks++;
      if (received != nops || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL rnd_w%0d count: got %0d transfers pending %0d required %0d/0",
                  w, received, exp_q.size(), nops);
      end
      step();
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_width8();
      test_random(1'b0, 250);
      test_random(1'b1, 250);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
